// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types and constants for the 8-bit subtractor datapath and
//            its downstream result buffer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Native subtractor datapath width
   localparam int ALU_WIDTH = 8;

   // Bit positions of each flag within a packed sub_flags_t
   localparam int FLAG_OVF    = 0;
   localparam int FLAG_NEG    = 1;
   localparam int FLAG_ZERO   = 2;
   localparam int FLAG_BORROW = 3;

   // Status flags captured alongside each subtractor result
   typedef struct packed {
      logic borrow;
      logic zero;
      logic neg;
      logic ovf;
   } sub_flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sub_result_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sub_result_fifo_mem
// Purpose  : DEPTH x WIDTH register array, one write port and one asynchronous
//            read port, all entries cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
module sub_result_fifo_mem #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage write; every entry returns to zero on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : sub_result_fifo_mem
`default_nettype wire

// File: rtl/sub_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sub_result_buffer
// Purpose  : Queues subtractor results {diff, borrow} with flags derived at
//            capture time (zero, neg, signed overflow) in a DEPTH-entry FIFO
//            with valid/ready handshakes on both sides. Head outputs come from
//            a dedicated register so they hold the last-read entry when empty.
// Config   : SUB_STICKY_BORROW_EN - enables the sticky borrow flag; when not
//            defined sticky_borrow is tied low and clr_sticky is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sub_result_buffer
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_diff,
   input  logic                       in_borrow,
   input  logic                       in_a_msb,
   input  logic                       in_b_msb,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_diff,
   output logic                       out_borrow,
   output logic                       out_zero,
   output logic                       out_neg,
   output logic                       out_ovf,
   output logic [$clog2(DEPTH+1)-1:0] count,
   input  logic                       clr_sticky,
   output logic                       sticky_borrow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = WIDTH + 4;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [EW-1:0] r_head;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_rd_next;
   logic [CW-1:0] w_count_next;
   logic          w_fwd;
   sub_flags_t    w_flags;
   logic [EW-1:0] w_wdata;
   logic [EW-1:0] w_rdata;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_push   = in_valid & ~w_full;
   assign w_pop    = out_ready & ~w_empty;

   // Flags are frozen at capture so the consumer never recomputes them
   assign w_flags.borrow = in_borrow;
   assign w_flags.zero   = ~|in_diff;
   assign w_flags.neg    = in_diff[WIDTH-1];
   assign w_flags.ovf    = (in_a_msb ^ in_b_msb) & (in_a_msb ^ in_diff[WIDTH-1]);
   assign w_wdata        = {w_flags, in_diff};

   // Head after this edge: the entry rd_ptr will point to next
   assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   // The next head slot is being written this very edge (buffer drains to one)
   assign w_fwd        = w_push & (r_wr_ptr == w_rd_next);

   sub_result_fifo_mem #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (w_rd_next),
      .o_rdata (w_rdata)
   );

   // Pointer and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
      end
   end

   // Registered head; holds the last-read entry while the buffer is empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
      end else if (w_count_next != '0) begin
         r_head <= w_fwd ? w_wdata : w_rdata;
      end
   end

   assign in_ready   = ~w_full;
   assign out_valid  = ~w_empty;
   assign count      = r_count;
   assign out_diff   = r_head[WIDTH-1:0];
   assign out_borrow = r_head[WIDTH+FLAG_BORROW];
   assign out_zero   = r_head[WIDTH+FLAG_ZERO];
   assign out_neg    = r_head[WIDTH+FLAG_NEG];
   assign out_ovf    = r_head[WIDTH+FLAG_OVF];

`ifdef SUB_STICKY_BORROW_EN
   logic r_sticky;

   // Sticky borrow: a borrowing push wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (w_push & in_borrow) begin
         r_sticky <= 1'b1;
      end else if (clr_sticky) begin
         r_sticky <= 1'b0;
      end
   end

   assign sticky_borrow = r_sticky;
`else
   logic w_unused_clr;

   assign w_unused_clr  = clr_sticky;
   assign sticky_borrow = 1'b0;
`endif

endmodule : sub_result_buffer
`default_nettype wire

// File: tb/tb_sub_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_result_buffer
// Purpose  : Self-checking bench for sub_result_buffer (WIDTH=8, DEPTH=4).
//            Expected values come from constant vectors and from a queue model
//            that derives flags from plain integer arithmetic on A and B.
// Config   : SUB_STICKY_BORROW_EN - selects the expected sticky behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_result_buffer;

   localparam int DEPTH = 4;
`ifdef SUB_STICKY_BORROW_EN
   localparam bit STICKY_EN = 1'b1;
`else
   localparam bit STICKY_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_diff = '0;
   logic       in_borrow = 1'b0;
   logic       in_a_msb = 1'b0;
   logic       in_b_msb = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_diff;
   logic       out_borrow, out_zero, out_neg, out_ovf;
   logic [2:0] count;
   logic       clr_sticky = 1'b0;
   logic       sticky_borrow;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] diff;
      logic       borrow, zero, neg, ovf;
   } ent_t;

   typedef struct {
      logic [7:0] a, b;
      logic [7:0] e_diff;
      logic       e_borrow, e_zero, e_neg, e_ovf;
   } vec_t;

   ent_t mq[$];
   logic m_sticky = 1'b0;

   sub_result_buffer #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_diff       (in_diff),
      .in_borrow     (in_borrow),
      .in_a_msb      (in_a_msb),
      .in_b_msb      (in_b_msb),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_diff      (out_diff),
      .out_borrow    (out_borrow),
      .out_zero      (out_zero),
      .out_neg       (out_neg),
      .out_ovf       (out_ovf),
      .count         (count),
      .clr_sticky    (clr_sticky),
      .sticky_borrow (sticky_borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result from integer arithmetic on the original operands
   function automatic ent_t ref_sub(input logic [7:0] a, input logic [7:0] b);
      ent_t e;
      int   sd;
      sd       = int'($signed(a)) - int'($signed(b));
      e.diff   = 8'(int'(a) - int'(b));
      e.borrow = (int'(a) < int'(b));
      e.zero   = (e.diff == 8'd0);
      e.neg    = (int'(e.diff) >= 128);
      e.ovf    = (sd > 127) || (sd < -128);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic rdy, input logic clr);
      in_valid   = v;
      in_diff    = a - b;
      in_borrow  = (a < b);
      in_a_msb   = a[7];
      in_b_msb   = b[7];
      out_ready  = rdy;
      clr_sticky = clr;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
      chk({tag, ".count"}, 32'(count), 32'(mq.size()));
      chk({tag, ".sticky"}, 32'(sticky_borrow), 32'(m_sticky));
      if (mq.size() > 0) begin
         chk({tag, ".diff"}, 32'(out_diff), 32'(mq[0].diff));
         chk({tag, ".borrow"}, 32'(out_borrow), 32'(mq[0].borrow));
         chk({tag, ".zero"}, 32'(out_zero), 32'(mq[0].zero));
         chk({tag, ".neg"}, 32'(out_neg), 32'(mq[0].neg));
         chk({tag, ".ovf"}, 32'(out_ovf), 32'(mq[0].ovf));
      end
   endtask

   // One clock of stimulus, then update the model and compare
   task automatic step(input string tag, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic rdy, input logic clr);
      bit   push, pop;
      ent_t e;
      drive(v, a, b, rdy, clr);
      e    = ref_sub(a, b);
      push = v && (mq.size() < DEPTH);
      pop  = rdy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (push && e.borrow) m_sticky = STICKY_EN;
      else if (clr)         m_sticky = 1'b0;
      check_state(tag);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h10, 8'h90, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};

      // Reset state
      #2;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.count", 32'(count), 32'd0);
      chk("rst.out_diff", 32'(out_diff), 32'd0);
      chk("rst.flags", 32'({out_borrow, out_zero, out_neg, out_ovf}), 32'd0);
      chk("rst.sticky", 32'(sticky_borrow), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table vectors: single push into empty buffer, then pop
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
         #1;
         chk($sformatf("vec%0d.no_bypass", i), 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
         if (vecs[i].e_borrow) m_sticky = STICKY_EN;
         in_valid = 1'b0;
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d.diff", i), 32'(out_diff), 32'(vecs[i].e_diff));
         chk($sformatf("vec%0d.flags", i), 32'({out_borrow, out_zero, out_neg, out_ovf}),
             32'({vecs[i].e_borrow, vecs[i].e_zero, vecs[i].e_neg, vecs[i].e_ovf}));
         chk($sformatf("vec%0d.sticky", i), 32'(sticky_borrow), 32'(m_sticky));
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         chk($sformatf("vec%0d.drained", i), 32'(out_valid), 32'd0);
         chk($sformatf("vec%0d.hold_diff", i), 32'(out_diff), 32'(vecs[i].e_diff));
      end

      // Sticky clear, then fill to full with a dropped push during a pop
      step("clr0", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step("fill0", 1'b1, 8'h11, 8'h01, 1'b0, 1'b0);
      step("fill1", 1'b1, 8'h22, 8'h02, 1'b0, 1'b0);
      step("fill2", 1'b1, 8'h33, 8'h03, 1'b0, 1'b0);
      step("fill3", 1'b1, 8'h44, 8'h04, 1'b0, 1'b0);
      step("full_hold", 1'b1, 8'h55, 8'h05, 1'b0, 1'b0);
      step("full_pop", 1'b1, 8'hEE, 8'h00, 1'b1, 1'b0);
      chk("full_pop.count3", 32'(count), 32'd3);
      step("drain0", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      step("drain1", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      chk("drain1.last", 32'(out_diff), 32'h40);
      step("drain2", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      step("empty_ready", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

      // Concurrent push+pop at count=2, wrapping the write pointer
      step("cc0", 1'b1, 8'hA0, 8'h00, 1'b0, 1'b0);
      step("cc1", 1'b1, 8'hB0, 8'h00, 1'b0, 1'b0);
      step("cc2", 1'b1, 8'hC0, 8'h00, 1'b1, 1'b0);
      chk("cc2.count2", 32'(count), 32'd2);
      step("cc3", 1'b1, 8'hD0, 8'h00, 1'b1, 1'b0);
      chk("cc3.count2", 32'(count), 32'd2);
      step("cc4", 1'b1, 8'hE0, 8'h00, 1'b1, 1'b0);
      step("cc5", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      step("cc6", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

      // Sticky: set, clear-with-borrowing-push, clear alone
      step("st_set", 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
      step("st_both", 1'b1, 8'h01, 8'h03, 1'b0, 1'b1);
      step("st_clr", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      step("st_pop0", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      step("st_pop1", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

      // Reset mid-stream takes effect without a clock edge
      step("rs0", 1'b1, 8'h09, 8'h01, 1'b0, 1'b0);
      step("rs1", 1'b1, 8'h08, 8'h01, 1'b0, 1'b0);
      step("rs2", 1'b1, 8'h07, 8'h09, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rs.count", 32'(count), 32'd0);
      chk("rs.out_valid", 32'(out_valid), 32'd0);
      chk("rs.in_ready", 32'(in_ready), 32'd1);
      chk("rs.sticky", 32'(sticky_borrow), 32'd0);
      chk("rs.out_diff", 32'(out_diff), 32'd0);
      mq.delete();
      m_sticky = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("rs_after", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

      // Randomised traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sub_result_buffer
`default_nettype wire
